// File: rtl/tape_mem_arb.sv
// Round-robin arbiter sharing one byte-wide SDRAM port between tape reads (A) and loader writes (B).
// Optional ack timeout/abort enabled by defining TAPE_ARB_TIMEOUT_EN.
module tape_mem_arb #(
    parameter int unsigned AW      = 25,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          a_rd,
    input  logic [AW-1:0] a_addr,
    output logic          a_rd_en,
    output logic [7:0]    a_din,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_data,
    output logic          b_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_din,
    input  logic          mem_ack,
    output logic          err_timeout
);

    typedef enum logic [1:0] {IDLE, A_RD, A_HOLD, B_WR} state_t;

    // The abort counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT == 0 || TIMEOUT > 65536) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65536");
    end

    state_t        state, state_n;
    logic          last_a, last_a_n;
    logic          a_rd_en_n, b_ack_n, mem_req_n, mem_we_n;
    logic [7:0]    a_din_n, mem_wdata_n;
    logic [AW-1:0] mem_addr_n;
    logic          a_pend, b_pend, grant_a, grant_b, timed_out;

    // Pending sides; on a tie the side not served last wins.
    assign a_pend  = a_rd && !a_rd_en;
    assign b_pend  = b_wr;
    assign grant_a = a_pend && (!b_pend || !last_a);
    assign grant_b = b_pend && (!a_pend || last_a);

`ifdef TAPE_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt, cnt_n;
    logic        err_n;

    assign timed_out = (cnt == TO_LAST);

    always_comb begin
        cnt_n = cnt;
        err_n = err_timeout;
        if (state == IDLE && (grant_a || grant_b)) begin
            cnt_n = 16'd0;
        end else if (state == A_RD || state == B_WR) begin
            cnt_n = cnt + 16'd1;
            if (!mem_ack && timed_out) begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt         <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            err_timeout <= err_n;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        last_a_n    = last_a;
        a_rd_en_n   = a_rd_en;
        a_din_n     = a_din;
        b_ack_n     = 1'b0;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        case (state)
            IDLE: begin
                if (grant_a) begin
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = a_addr;
                    last_a_n   = 1'b1;
                    state_n    = A_RD;
                end else if (grant_b) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = b_addr;
                    mem_wdata_n = b_data;
                    last_a_n    = 1'b0;
                    state_n     = B_WR;
                end
            end
            A_RD: begin
                // A tape that let go of a_rd mid-cycle gets no strobe.
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    a_din_n   = mem_din;
                    a_rd_en_n = a_rd;
                    state_n   = a_rd ? A_HOLD : IDLE;
                end else if (timed_out) begin
                    mem_req_n = 1'b0;
                    a_din_n   = 8'hFF;
                    a_rd_en_n = a_rd;
                    state_n   = a_rd ? A_HOLD : IDLE;
                end
            end
            A_HOLD: begin
                if (!a_rd) begin
                    a_rd_en_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            B_WR: begin
                if (mem_ack || timed_out) begin
                    mem_req_n = 1'b0;
                    b_ack_n   = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_a    <= 1'b0;
            a_rd_en   <= 1'b0;
            a_din     <= 8'h00;
            b_ack     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            state     <= state_n;
            last_a    <= last_a_n;
            a_rd_en   <= a_rd_en_n;
            a_din     <= a_din_n;
            b_ack     <= b_ack_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_tape_mem_arb.sv
// Self-checking bench for tape_mem_arb: vector table, directed corner sequences and
// randomized concurrent traffic checked against a byte-memory reference model.
module tb_tape_mem_arb;

    localparam int unsigned AW    = 25;
    localparam int          LIMIT = 300;

    logic          clk_sys, reset;
    logic          a_rd, a_rd_en, b_wr, b_ack;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [7:0]    a_din, b_data, mem_wdata, mem_din;
    logic          mem_req, mem_we, mem_ack, err_timeout;
    logic          resp_ack, manual_ack;

    assign mem_ack = resp_ack | manual_ack;

    tape_mem_arb #(.AW(AW), .TIMEOUT(16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_rd(a_rd), .a_addr(a_addr), .a_rd_en(a_rd_en), .a_din(a_din),
        .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_din(mem_din), .mem_ack(mem_ack), .err_timeout(err_timeout)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- memory responder (SDRAM stand-in) ----------------
    logic [7:0] mem_arr [int];
    bit  resp_en  = 1'b1;
    bit  rand_lat = 1'b0;
    int  ack_lat  = 0;
    int  cur_lat, wait_cnt;
    bit  ack_given;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    function automatic logic [7:0] mem_rd(input int a);
        return mem_arr.exists(a) ? mem_arr[a] : pat(a);
    endfunction

    always @(negedge clk_sys) begin
        resp_ack = 1'b0;
        mem_din  = 8'($urandom);
        if (!mem_req || reset) begin
            ack_given = 1'b0;
            wait_cnt  = 0;
        end else if (resp_en && !ack_given) begin
            if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
            if (wait_cnt >= cur_lat) begin
                resp_ack  = 1'b1;
                ack_given = 1'b1;
                if (mem_we) mem_arr[int'(mem_addr)] = mem_wdata;
                else        mem_din = mem_rd(int'(mem_addr));
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } grant_t;

    grant_t        grant_log[$];
    int            back_cnt = 0, rise_cnt = 0, stab_err = 0;
    logic          req_prev = 1'b0, rden_prev = 1'b0, we_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic [7:0]    wdata_prev = 8'h00;

    always @(negedge clk_sys) begin
        if (mem_req && !req_prev) grant_log.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_req && req_prev &&
            (mem_addr != addr_prev || mem_wdata != wdata_prev || mem_we != we_prev)) stab_err++;
        if (b_ack) back_cnt++;
        if (a_rd_en && !rden_prev) rise_cnt++;
        req_prev   = mem_req;
        rden_prev  = a_rd_en;
        we_prev    = mem_we;
        addr_prev  = mem_addr;
        wdata_prev = mem_wdata;
    end

    // ---------------- helpers ----------------
    function automatic bit sig(input int which);
        case (which)
            0:       return a_rd_en;
            1:       return b_ack;
            2:       return mem_req;
            default: return !mem_req;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!sig(which) && n < LIMIT);
        checks++;
        if (!sig(which)) begin
            errors++;
            $display("FAIL %s wait: event absent after %0d cycles", nm, LIMIT);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_rd  = 1'b0;
        b_wr  = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int lat, input string nm,
                           input logic [7:0] exp);
        int n;
        ack_lat = lat;
        a_addr  = addr;
        a_rd    = 1'b1;
        wait_for(2, nm, n);
        chk({nm, " we"}, 32'(mem_we), 32'd0);
        chk({nm, " addr"}, 32'(mem_addr), 32'(addr));
        wait_for(0, nm, n);
        chk({nm, " din"}, 32'(a_din), 32'(exp));
        a_rd = 1'b0;
        @(negedge clk_sys);
        chk({nm, " rd_en fall"}, 32'(a_rd_en), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] data, input int lat,
                            input string nm);
        int n;
        ack_lat = lat;
        b_addr  = addr;
        b_data  = data;
        b_wr    = 1'b1;
        wait_for(2, nm, n);
        chk({nm, " we"}, 32'(mem_we), 32'd1);
        chk({nm, " addr"}, 32'(mem_addr), 32'(addr));
        chk({nm, " wdata"}, 32'(mem_wdata), 32'(data));
        wait_for(1, nm, n);
        b_wr = 1'b0;
        @(negedge clk_sys);
        chk({nm, " ack pulse"}, 32'(b_ack), 32'd0);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            lat;
        logic [7:0]    exp;
    } vec_t;

    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   n, b0, r0;
        string nm;

        reset = 1'b1; a_rd = 1'b0; a_addr = '0; b_wr = 1'b0; b_addr = '0; b_data = 8'h00;
        manual_ack = 1'b0;

        // reset values
        @(negedge clk_sys);
        chk("reset a_rd_en", 32'(a_rd_en), 32'd0);
        chk("reset a_din", 32'(a_din), 32'd0);
        chk("reset b_ack", 32'(b_ack), 32'd0);
        chk("reset mem_req/we", 32'({mem_req, mem_we}), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset err_timeout", 32'(err_timeout), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;

        // single tape read, ack three cycles after the request
        mem_arr[32'h123] = 8'h5A;
        ack_lat = 2;
        a_addr  = 25'h000123;
        a_rd    = 1'b1;
        wait_for(2, "single req", n);
        chk("single grant latency", 32'(n), 32'd1);
        chk("single we", 32'(mem_we), 32'd0);
        chk("single addr", 32'(mem_addr), 32'h123);
        wait_for(0, "single rd_en", n);
        chk("single rd_en latency", 32'(n), 32'd3);
        chk("single req dropped", 32'(mem_req), 32'd0);
        chk("single din", 32'(a_din), 32'h5A);
        @(negedge clk_sys);
        chk("single rd_en held", 32'(a_rd_en), 32'd1);
        a_rd = 1'b0;
        @(negedge clk_sys);
        chk("single rd_en fall", 32'(a_rd_en), 32'd0);

        // contention right after reset: A first, then alternating
        do_reset();
        ack_lat = 0;
        grant_log.delete();
        for (int r = 0; r < 4; r++) begin
            a_addr = 25'(32'h300 + r);
            b_addr = 25'(32'h310 + r);
            b_data = 8'(8'hC0 + r);
            a_rd   = 1'b1;
            b_wr   = 1'b1;
            fork
                begin int m; wait_for(0, "contention A", m); a_rd = 1'b0; end
                begin int m; wait_for(1, "contention B", m); b_wr = 1'b0; end
            join
            @(negedge clk_sys);
        end
        chk("contention grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            nm = $sformatf("contention grant %0d", i);
            chk(nm, 32'(grant_log[i].we), 32'(i % 2));
        end

        // loader burst with b_wr held high between writes
        repeat (2) @(negedge clk_sys);
        grant_log.delete();
        b0 = back_cnt; r0 = rise_cnt;
        ack_lat = 0;
        for (int i = 0; i < 8; i++) begin
            b_addr = 25'(i);
            b_data = 8'(i);
            b_wr   = 1'b1;
            wait_for(1, "burst", n);
        end
        b_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("burst b_ack count", 32'(back_cnt - b0), 32'd8);
        chk("burst a_rd_en rises", 32'(rise_cnt - r0), 32'd0);
        chk("burst grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            nm = $sformatf("burst write %0d", i);
            chk(nm, {7'd0, grant_log[i].we, grant_log[i].wdata[7:0], grant_log[i].addr[15:0]},
                {7'd0, 1'b1, 8'(i), 16'(i)});
        end

        // vector table
        vecs[0] = '{1'b1, 25'h0000040,  8'h99, 1, 8'h00};
        vecs[1] = '{1'b0, 25'h0000040,  8'h00, 2, 8'h99};
        vecs[2] = '{1'b1, 25'h1FFFFFF,  8'hFF, 0, 8'h00};
        vecs[3] = '{1'b0, 25'h1FFFFFF,  8'h00, 0, 8'hFF};
        vecs[4] = '{1'b0, 25'h0000003,  8'h00, 3, 8'h03};
        vecs[5] = '{1'b1, 25'h0000007,  8'h80, 0, 8'h00};
        vecs[6] = '{1'b0, 25'h0000007,  8'h00, 1, 8'h80};
        vecs[7] = '{1'b0, 25'h000009A,  8'h00, 0, 8'h3F};
        for (int i = 0; i < 8; i++) begin
            nm = $sformatf("vec %0d", i);
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].lat, nm);
            else            do_read(vecs[i].addr, vecs[i].lat, nm, vecs[i].exp);
            @(negedge clk_sys);
        end

        // abort: tape drops a_rd while the read is in flight
        mem_arr[32'h3AB] = 8'hEE;
        r0 = rise_cnt;
        ack_lat = 3;
        a_addr  = 25'h00003AB;
        a_rd    = 1'b1;
        wait_for(2, "abort req", n);
        a_rd = 1'b0;
        wait_for(3, "abort ack", n);
        repeat (2) @(negedge clk_sys);
        chk("abort rd_en silent", 32'(rise_cnt - r0), 32'd0);
        chk("abort rd_en low", 32'(a_rd_en), 32'd0);
        mem_arr[32'h3AB] = 8'h3C;
        do_read(25'h00003AB, 0, "abort reread", 8'h3C);

        // reset in the middle of a write cycle, then a stray ack
        resp_en = 1'b0;
        b0 = back_cnt; r0 = rise_cnt;
        b_addr = 25'h0000077;
        b_data = 8'h42;
        b_wr   = 1'b1;
        wait_for(2, "rstmid req", n);
        @(posedge clk_sys);
        #2 reset = 1'b1;
        #1;
        chk("rstmid mem_req", 32'(mem_req), 32'd0);
        chk("rstmid mem_we/addr/wdata", 32'({mem_we, mem_addr[15:0], mem_wdata}), 32'd0);
        b_wr = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        manual_ack = 1'b1;
        @(negedge clk_sys);
        manual_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rstmid late ack b_ack", 32'(back_cnt - b0), 32'd0);
        chk("rstmid late ack rd_en", 32'(rise_cnt - r0), 32'd0);
        chk("rstmid stays idle", 32'(mem_req), 32'd0);
        resp_en = 1'b1;

`ifdef TAPE_ARB_TIMEOUT_EN
        // no ack at all: abort after TIMEOUT cycles with 8'hFF
        resp_en = 1'b0;
        a_addr  = 25'h0000055;
        a_rd    = 1'b1;
        wait_for(2, "timeout req", n);
        n = 0;
        while (mem_req && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("timeout req cycles", 32'(n), 32'd16);
        chk("timeout rd_en", 32'(a_rd_en), 32'd1);
        chk("timeout din", 32'(a_din), 32'hFF);
        chk("timeout err", 32'(err_timeout), 32'd1);
        a_rd = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("timeout err sticky", 32'(err_timeout), 32'd1);
        resp_en = 1'b1;
        do_reset();
        @(negedge clk_sys);
        chk("timeout err cleared", 32'(err_timeout), 32'd0);
`endif

        // randomized concurrent traffic against the byte-memory model
        rand_lat = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int a, m;
                    a      = 32'h200 + int'($urandom_range(0, 15));
                    a_addr = 25'(a);
                    a_rd   = 1'b1;
                    wait_for(0, "rand read", m);
                    chk($sformatf("rand read %0d @%0h", i, a), 32'(a_din), 32'(ref_rd(a)));
                    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
                    a_rd = 1'b0;
                    @(negedge clk_sys);
                    chk("rand rd_en fall", 32'(a_rd_en), 32'd0);
                    repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    int a, m;
                    logic [7:0] d;
                    a      = 32'h200 + int'($urandom_range(0, 15));
                    d      = 8'($urandom);
                    b_addr = 25'(a);
                    b_data = d;
                    b_wr   = 1'b1;
                    wait_for(1, "rand write", m);
                    ref_mem[a] = d;
                    b_wr = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                end
            end
        join
        repeat (3) @(negedge clk_sys);

        chk("addr/data stable during req", 32'(stab_err), 32'd0);
`ifndef TAPE_ARB_TIMEOUT_EN
        chk("err_timeout tied low", 32'(err_timeout), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
